// File: rtl/seq_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seq_decoder_pkg
// Shared definitions for seq_onehot_decoder and its dwell_counter helper.
//   - mode encodings (MODE_LEVEL / MODE_PULSE / MODE_SWEEP, 2'b11 aliases LEVEL)
//   - state_t: decoder FSM states
//   - onehot(): selector to one-hot conversion, sized for the widest supported
//     selector; callers cast the result down to their own output width.
// -----------------------------------------------------------------------------
package seq_decoder_pkg;

    // Largest selector width the helper function supports (SEL_W <= MAX_SEL_W).
    localparam int MAX_SEL_W   = 8;
    localparam int MAX_NUM_OUT = 2 ** MAX_SEL_W;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_SWEEP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_STROBE,
        ST_SWEEP
    } state_t;

    function automatic logic [MAX_NUM_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_NUM_OUT-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/seq_onehot_decoder_dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Counts 0..DWELL-1 while tick is high, wrapping to 0 after the terminal count.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   load        clear the count to 0 (takes priority over tick)
//   tick        advance the count by one
//   tc          high while the count equals DWELL-1 (combinational)
// -----------------------------------------------------------------------------
module dwell_counter #(
    parameter int DWELL   = 4,
    parameter int DWELL_W = $clog2(DWELL + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic tc
);

    logic [DWELL_W-1:0] cnt;

    assign tc = (cnt == DWELL_W'(DWELL - 1));

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= tc ? '0 : cnt + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/seq_onehot_decoder.sv
// -----------------------------------------------------------------------------
// seq_onehot_decoder
// Registered SEL_W -> 2**SEL_W one-hot decoder with valid/ready request intake
// and three output modes: LEVEL (hold), PULSE (one-cycle strobe) and SWEEP
// (walk from the selected index up to the top one, DWELL cycles per index).
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   enable      global enable; low forces the outputs off and blocks requests
//   mode        00 LEVEL, 01 PULSE, 10 SWEEP, 11 LEVEL
//   selector    index to decode, sampled on accept
//   req_valid   request present
//   req_ready   request can be accepted (enable and not sweeping)
//   dout        registered one-hot output (or all zero)
//   busy        high while a sweep is running
//   sweep_done  one-cycle pulse when a sweep finishes on its own
// Optional (macro SEQ_DECODER_SEL_PARITY_EN):
//   sel_par     even-parity bit over selector
//   par_err     one-cycle pulse when an accepted request fails parity; such a
//               request is consumed but leaves state and dout untouched
// -----------------------------------------------------------------------------
module seq_onehot_decoder
    import seq_decoder_pkg::*;
#(
    parameter int SEL_W = 5,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [SEL_W-1:0]     selector,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic [2**SEL_W-1:0]  dout,
    output logic                 busy,
    output logic                 sweep_done
`ifdef SEQ_DECODER_SEL_PARITY_EN
    ,
    input  logic                 sel_par,
    output logic                 par_err
`endif
);

    localparam int NUM_OUT = 2 ** SEL_W;
    localparam int DWELL_W = $clog2(DWELL + 1);

    state_t           state;
    logic [SEL_W-1:0] idx;      // latched selector; advances during a sweep
    logic             accept;
    logic             act;      // accepted and parity-clean
    logic             par_ok;
    logic             dwell_tc;
    logic             last_idx;

    assign req_ready = enable && (state != ST_SWEEP);
    assign accept    = req_valid && req_ready;
    assign act       = accept && par_ok;
    assign last_idx  = (idx == SEL_W'(NUM_OUT - 1));

`ifdef SEQ_DECODER_SEL_PARITY_EN
    assign par_ok = (sel_par == ^selector);

    always_ff @(posedge clk) begin
        if (!rst_n) par_err <= 1'b0;
        else        par_err <= accept && !par_ok;
    end
`else
    assign par_ok = 1'b1;
`endif

    // Counter restarts on every new request and whenever enable drops, so a
    // sweep always begins with a full dwell on its first index.
    dwell_counter #(
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (act || !enable),
        .tick  (state == ST_SWEEP),
        .tc    (dwell_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            dout       <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (!enable) begin
                state <= ST_IDLE;
                dout  <= '0;
                busy  <= 1'b0;
            end else if (act) begin
                // New request replaces whatever is showing, with no zero gap.
                idx  <= selector;
                dout <= NUM_OUT'(onehot(MAX_SEL_W'(selector)));
                case (mode)
                    MODE_PULSE: begin
                        state <= ST_STROBE;
                        busy  <= 1'b0;
                    end
                    MODE_SWEEP: begin
                        state <= ST_SWEEP;
                        busy  <= 1'b1;
                    end
                    default: begin
                        state <= ST_HOLD;
                        busy  <= 1'b0;
                    end
                endcase
            end else begin
                case (state)
                    ST_STROBE: begin
                        state <= ST_IDLE;
                        dout  <= '0;
                    end
                    ST_SWEEP: begin
                        if (dwell_tc) begin
                            if (last_idx) begin
                                // Sweeps stop at the top index rather than wrap.
                                state      <= ST_IDLE;
                                dout       <= '0;
                                busy       <= 1'b0;
                                sweep_done <= 1'b1;
                            end else begin
                                idx  <= idx + SEL_W'(1);
                                dout <= NUM_OUT'(onehot(MAX_SEL_W'(idx + SEL_W'(1))));
                            end
                        end
                    end
                    default: ;  // IDLE and HOLD keep their output
                endcase
            end
        end
    end

endmodule
